monitor_contador_modulo9: RTL

MONITOR_CONTADOR_MODULO9 -- requirements
Module: monitor_contador_modulo9

---
 rtl/monitor_contador_modulo9.sv | 116 +++++++++++
 1 files changed

// File: rtl/monitor_contador_modulo9.sv
// Sequence monitor for an upstream mod-MODULO counter: checks each sampled value,
// counts completed wraps and latches the first out-of-sequence sample.
module monitor_contador_modulo9 #(
    parameter int unsigned MODULO   = 9,
    parameter int unsigned CICLOS_W = 8
) (
    input  logic                clk_input,
    input  logic                clear_input,
    input  logic [3:0]          contador_input,
    input  logic                enable_input,
    input  logic                resync_input,
    output logic                wrap_output,
    output logic [CICLOS_W-1:0] ciclos_output,
    output logic                erro_output,
    output logic [3:0]          erro_valor_output,
    output logic [1:0]          estado_output
);

    localparam logic [4:0] MOD_EXT = 5'(MODULO);
    localparam logic [3:0] LAST    = 4'(MODULO - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        TRACK   = 2'b01,
        FAULT   = 2'b10,
        ILLEGAL = 2'b11
    } estado_t;

    estado_t             estado_q, estado_d;
    logic [3:0]          prev_q, prev_d;
    logic                wrap_q, wrap_d;
    logic [CICLOS_W-1:0] ciclos_q, ciclos_d;
    logic                erro_q, erro_d;
    logic [3:0]          valor_q, valor_d;
    logic [3:0]          esperado;

    // State and output registers; clear is sampled on the clock edge only
    always_ff @(posedge clk_input) begin
        if (!clear_input) begin
            estado_q <= IDLE;
            prev_q   <= 4'd0;
            wrap_q   <= 1'b0;
            ciclos_q <= '0;
            erro_q   <= 1'b0;
            valor_q  <= 4'd0;
        end else begin
            estado_q <= estado_d;
            prev_q   <= prev_d;
            wrap_q   <= wrap_d;
            ciclos_q <= ciclos_d;
            erro_q   <= erro_d;
            valor_q  <= valor_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        estado_d = estado_q;
        prev_d   = prev_q;
        wrap_d   = 1'b0;
        ciclos_d = ciclos_q;
        erro_d   = erro_q;
        valor_d  = valor_q;
        esperado = (prev_q == LAST) ? 4'd0 : prev_q + 4'd1;

        case (estado_q)
            IDLE: begin
                if (enable_input) begin
                    if ({1'b0, contador_input} >= MOD_EXT) begin
                        estado_d = FAULT;
                        erro_d   = 1'b1;
                        valor_d  = contador_input;
                    end else begin
                        estado_d = TRACK;
                        prev_d   = contador_input;
                    end
                end
            end
            TRACK: begin
                if (enable_input) begin
                    if (contador_input == esperado) begin
                        prev_d = contador_input;
                        if (prev_q == LAST) begin
                            wrap_d = 1'b1;
                            if (ciclos_q != '1) begin
                                ciclos_d = ciclos_q + CICLOS_W'(1);
                            end
                        end
                    end else if (contador_input != prev_q) begin
                        estado_d = FAULT;
                        erro_d   = 1'b1;
                        valor_d  = contador_input;
                    end
                end
            end
            FAULT: begin
                // Resync wins over any sample presented on the same edge
                if (resync_input) begin
                    estado_d = IDLE;
                    erro_d   = 1'b0;
                    valor_d  = 4'd0;
                end
            end
            default: begin
                estado_d = IDLE;
            end
        endcase
    end

    assign wrap_output       = wrap_q;
    assign ciclos_output     = ciclos_q;
    assign erro_output       = erro_q;
    assign erro_valor_output = valor_q;
    assign estado_output     = estado_q;

endmodule
